// File: rtl/riscv_writeback.sv
// riscv_writeback: register-file writeback arbiter.
// ALU results always win the single write port; load results that return
// from memory wait in a small FIFO and drain whenever the ALU is idle.
// A 32-bit scoreboard marks registers that still have a load in flight.
module riscv_writeback #(
   parameter int LDQ_DEPTH = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_data,
   output logic        we,
   output logic [4:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic [31:0] busy_mask
);

   localparam int PTR_W = $clog2(LDQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Load-result queue storage.
   logic [4:0]       q_rd_q   [LDQ_DEPTH];
   logic [31:0]      q_data_q [LDQ_DEPTH];

   // Queue control state.
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Registered write port and scoreboard.
   logic             we_q, we_d;
   logic [4:0]       rd_addr_q, rd_addr_d;
   logic [31:0]      rd_data_q, rd_data_d;
   logic [31:0]      busy_q, busy_d;

   logic             push;
   logic             pop;
   logic [4:0]       head_rd;
   logic [31:0]      head_data;

   // The queue only accepts while out of reset and not full.
   assign ld_ready  = resetn && (count_q < CNT_W'(LDQ_DEPTH));
   assign push      = ld_valid && ld_ready;
   // A queued load drains only in a cycle the ALU leaves the port free.
   assign pop       = !alu_valid && (count_q != '0);
   assign head_rd   = q_rd_q[rd_ptr_q];
   assign head_data = q_data_q[rd_ptr_q];

   assign we        = we_q;
   assign rd_addr   = rd_addr_q;
   assign rd_data   = rd_data_q;
   assign busy_mask = busy_q;

   // Select the next register-file write: ALU first, then queue head.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      we_d      = 1'b0;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      if (alu_valid) begin
         we_d      = (alu_rd != 5'd0);
         rd_addr_d = alu_rd;
         rd_data_d = alu_data;
      end else if (pop) begin
         we_d      = (head_rd != 5'd0);
         rd_addr_d = head_rd;
         rd_data_d = head_data;
      end
   end

   // Scoreboard update: pop clears, issue sets afterwards so a set wins.
   always_comb begin
      // NOTE: blocking assignments in order give the later set precedence
      // over the earlier clear when both hit the same bit.
      busy_d = busy_q;
      if (pop) begin
         busy_d[head_rd] = 1'b0;
      end
      if (issue_valid && (issue_rd != 5'd0)) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Queue pointer and occupancy update; pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // Control and output registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values of the others.
      if (!resetn) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         we_q      <= 1'b0;
         rd_addr_q <= 5'd0;
         rd_data_q <= 32'd0;
         busy_q    <= 32'd0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         we_q      <= we_d;
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
         busy_q    <= busy_d;
      end
   end

   // Queue storage write on push.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; an empty count makes stale
      // entries unreachable, and leaving it out keeps it a plain RAM.
      if (push) begin
         q_rd_q[wr_ptr_q]   <= ld_rd;
         q_data_q[wr_ptr_q] <= ld_data;
      end
   end

endmodule

// File: tb/tb_riscv_writeback.sv
// tb_riscv_writeback: directed table, multi-cycle corner sequences and a
// randomized run against a queue-based reference model.
module tb_riscv_writeback;

   localparam int DEPTH = 2;

   logic        clk;
   logic        resetn;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        we;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [31:0] busy_mask;

   int pass_cnt = 0;
   int total_cnt = 0;

   riscv_writeback #(.LDQ_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .issue_valid(issue_valid),
      .issue_rd   (issue_rd),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_rd      (ld_rd),
      .ld_data    (ld_data),
      .we         (we),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .busy_mask  (busy_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        alu_v;
      logic [4:0]  alu_rd;
      logic [31:0] alu_data;
      logic        iss_v;
      logic [4:0]  iss_rd;
      logic        ld_v;
      logic [4:0]  ld_rd;
      logic [31:0] ld_data;
      logic        exp_we;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
      logic [31:0] exp_busy;
      logic        exp_ready;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ld_entry_t;

   vec_t vecs [12];

   // Reference model state.
   ld_entry_t   mq[$];
   logic [31:0] m_busy;
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_out(input string name, input logic e_we, input logic [4:0] e_addr,
                             input logic [31:0] e_data, input logic [31:0] e_busy,
                             input logic e_ready);
      check({name, ".we"},       32'(we),        32'(e_we));
      check({name, ".rd_addr"},  32'(rd_addr),   32'(e_addr));
      check({name, ".rd_data"},  rd_data,        e_data);
      check({name, ".busy"},     busy_mask,      e_busy);
      check({name, ".ld_ready"}, 32'(ld_ready),  32'(e_ready));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid   = 1'b0;
      alu_rd      = 5'd0;
      alu_data    = 32'd0;
      issue_valid = 1'b0;
      issue_rd    = 5'd0;
      ld_valid    = 1'b0;
      ld_rd       = 5'd0;
      ld_data     = 32'd0;
   endtask

   task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic iv, input logic [4:0] ir,
                        input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
      alu_valid   = av;
      alu_rd      = ar;
      alu_data    = ad;
      issue_valid = iv;
      issue_rd    = ir;
      ld_valid    = lv;
      ld_rd       = lr;
      ld_data     = ldd;
   endtask

   task automatic do_reset(input string name);
      resetn = 1'b0;
      idle_inputs();
      repeat (2) tick();
      expect_out({name, ".in_reset"}, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
      resetn = 1'b1;
      #1;
      check({name, ".ready_after_release"}, 32'(ld_ready), 32'd1);
      mq.delete();
      m_busy = 32'd0;
      m_we   = 1'b0;
      m_addr = 5'd0;
      m_data = 32'd0;
   endtask

   // Apply the current inputs to the model for one rising edge.
   task automatic model_edge();
      ld_entry_t e;
      bit        can_push;
      can_push = ld_valid && (mq.size() < DEPTH);
      m_we = 1'b0;
      if (alu_valid) begin
         m_we   = (alu_rd != 0);
         m_addr = alu_rd;
         m_data = alu_data;
      end else if (mq.size() > 0) begin
         e      = mq.pop_front();
         m_we   = (e.rd != 0);
         m_addr = e.rd;
         m_data = e.data;
         m_busy[e.rd] = 1'b0;
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      m_busy[0] = 1'b0;
      if (can_push) begin
         e.rd   = ld_rd;
         e.data = ld_data;
         mq.push_back(e);
      end
   endtask

   initial begin
      resetn = 1'b0;
      idle_inputs();

      // ---------------- table-driven directed vectors ----------------
      //           alu_v alu_rd alu_data        iss_v iss_rd ld_v ld_rd ld_data          we  addr  data             busy          ready
      vecs[0]  = '{1'b1, 5'd1,  32'd42,         1'b0, 5'd0,  1'b0, 5'd0, 32'd0,          1'b1, 5'd1, 32'd42,         32'h0,        1'b1};
      vecs[1]  = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  1'b0, 5'd0, 32'd0,          1'b0, 5'd1, 32'd42,         32'h0,        1'b1};
      vecs[2]  = '{1'b0, 5'd0,  32'd0,          1'b1, 5'd5,  1'b0, 5'd0, 32'd0,          1'b0, 5'd1, 32'd42,         32'h20,       1'b1};
      vecs[3]  = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  1'b1, 5'd5, 32'hDEADBEEF,   1'b0, 5'd1, 32'd42,         32'h20,       1'b1};
      vecs[4]  = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  1'b0, 5'd0, 32'd0,          1'b1, 5'd5, 32'hDEADBEEF,   32'h0,        1'b1};
      vecs[5]  = '{1'b1, 5'd0,  32'h55,         1'b0, 5'd0,  1'b0, 5'd0, 32'd0,          1'b0, 5'd0, 32'h55,         32'h0,        1'b1};
      vecs[6]  = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  1'b1, 5'd0, 32'h77,         1'b0, 5'd0, 32'h55,         32'h0,        1'b1};
      vecs[7]  = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  1'b0, 5'd0, 32'd0,          1'b0, 5'd0, 32'h77,         32'h0,        1'b1};
      vecs[8]  = '{1'b0, 5'd0,  32'd0,          1'b1, 5'd6,  1'b0, 5'd0, 32'd0,          1'b0, 5'd0, 32'h77,         32'h40,       1'b1};
      vecs[9]  = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  1'b1, 5'd6, 32'h66,         1'b0, 5'd0, 32'h77,         32'h40,       1'b1};
      vecs[10] = '{1'b0, 5'd0,  32'd0,          1'b1, 5'd6,  1'b0, 5'd0, 32'd0,          1'b1, 5'd6, 32'h66,         32'h40,       1'b1};
      vecs[11] = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  1'b0, 5'd0, 32'd0,          1'b0, 5'd6, 32'h66,         32'h40,       1'b1};

      do_reset("table");
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].alu_v, vecs[i].alu_rd, vecs[i].alu_data, vecs[i].iss_v, vecs[i].iss_rd,
               vecs[i].ld_v, vecs[i].ld_rd, vecs[i].ld_data);
         tick();
         expect_out($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_addr,
                    vecs[i].exp_data, vecs[i].exp_busy, vecs[i].exp_ready);
      end

      // ---------------- ALU priority while the queue fills ----------------
      do_reset("prio");
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0);
      tick();
      expect_out("prio.issued", 1'b0, 5'd0, 32'd0, 32'h18, 1'b1);
      drive(1'b1, 5'd3, 32'd100, 1'b0, 5'd0, 1'b1, 5'd3, 32'd7);
      tick();
      expect_out("prio.alu0", 1'b1, 5'd3, 32'd100, 32'h18, 1'b1);
      drive(1'b1, 5'd11, 32'd101, 1'b0, 5'd0, 1'b1, 5'd4, 32'd9);
      tick();
      expect_out("prio.alu1", 1'b1, 5'd11, 32'd101, 32'h18, 1'b0);
      drive(1'b1, 5'd12, 32'd102, 1'b0, 5'd0, 1'b1, 5'd8, 32'hBAD);
      tick();
      expect_out("prio.alu2", 1'b1, 5'd12, 32'd102, 32'h18, 1'b0);
      idle_inputs();
      tick();
      expect_out("prio.ld_x3", 1'b1, 5'd3, 32'd7, 32'h10, 1'b1);
      tick();
      expect_out("prio.ld_x4", 1'b1, 5'd4, 32'd9, 32'h0, 1'b1);
      tick();
      expect_out("prio.drained", 1'b0, 5'd4, 32'd9, 32'h0, 1'b1);

      // ---------------- reset with queued entries ----------------
      do_reset("rst");
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 1'b0, 5'd0, 32'd0);
      tick();
      drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b1, 5'd13, 32'h111);
      tick();
      drive(1'b1, 5'd9, 32'h98, 1'b0, 5'd0, 1'b1, 5'd14, 32'h222);
      tick();
      expect_out("rst.full", 1'b1, 5'd9, 32'h98, 32'h2000, 1'b0);
      idle_inputs();
      #2;
      resetn = 1'b0;
      #1;
      expect_out("rst.async", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
      repeat (2) tick();
      resetn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         expect_out($sformatf("rst.after%0d", i), 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
      end

      // ---------------- randomized run against the model ----------------
      do_reset("rand");
      for (int i = 0; i < 3000; i++) begin
         alu_valid   = ($urandom_range(0, 99) < 45);
         alu_rd      = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         alu_data    = $urandom;
         issue_valid = ($urandom_range(0, 99) < 30);
         issue_rd    = 5'($urandom_range(0, 15));
         ld_valid    = ($urandom_range(0, 99) < 50);
         ld_rd       = 5'($urandom_range(0, 15));
         ld_data     = $urandom;
         model_edge();
         tick();
         expect_out($sformatf("rand%0d", i), m_we, m_addr, m_data, m_busy,
                    (mq.size() < DEPTH) ? 1'b1 : 1'b0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
